// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes and multiply-controller state encoding
package alu_pkg;
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_NAND  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SHL   = 4'd6;
  localparam logic [3:0] ALU_SHR   = 4'd7;
  localparam logic [3:0] ALU_PASSB = 4'd8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_SHL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
endpackage

// File: rtl/alu.sv
// alu: shared single-cycle 64-bit ALU with zero/negative flags
module alu
  import alu_pkg::*;
(
  input  logic [3:0]  opt,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [5:0]  shamt,
  output logic [63:0] res,
  output logic        z,
  output logic        n
);
  always_comb begin
    case (opt)
      ALU_ADD:   res = a + b;
      ALU_SUB:   res = a - b;
      ALU_AND:   res = a & b;
      ALU_OR:    res = a | b;
      ALU_NAND:  res = ~(a & b);
      ALU_XOR:   res = a ^ b;
      ALU_SHL:   res = a << shamt;
      ALU_SHR:   res = a >> shamt;
      ALU_PASSB: res = b;
      default:   res = '0;
    endcase
  end
  assign z = (res == '0);
  assign n = res[63];
endmodule

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add 64x64 multiply (low half) driving the shared ALU
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [5:0]  alu_shamt,
  output logic [3:0]  alu_opt,
  input  logic [63:0] alu_res
);
  logic [1:0]  state;
  logic [63:0] p, m, q;
  logic [6:0]  cnt;
  logic        last;
  // last shift: no multiplier bits left, or all 64 positions consumed
  assign last = EARLY_EXIT ? (q[63:1] == '0) : (cnt == 7'd63);
  assign busy = (state == S_ADD) || (state == S_SHL);
  assign done = (state == S_DONE);
  always_comb begin
    alu_opt   = (state == S_SHL) ? ALU_SHL : ALU_ADD;
    alu_a     = (state == S_ADD) ? p : (state == S_SHL) ? m : '0;
    alu_b     = (state == S_ADD) ? m : '0;
    alu_shamt = (state == S_SHL) ? 6'd1 : 6'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      p       <= '0;
      m       <= '0;
      q       <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          p     <= '0;
          m     <= op_a;
          q     <= op_b;
          cnt   <= '0;
          state <= (EARLY_EXIT && op_b == '0) ? S_DONE : op_b[0] ? S_ADD : S_SHL;
          if (EARLY_EXIT && op_b == '0) product <= '0;
        end
        S_ADD: begin
          p     <= alu_res;
          state <= S_SHL;
        end
        S_SHL: begin
          m     <= alu_res;
          q     <= q >> 1;
          cnt   <= cnt + 7'd1;
          state <= last ? S_DONE : q[1] ? S_ADD : S_SHL;
          if (last) product <= p;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed and random checks of both EARLY_EXIT variants against the real ALU
module tb_alu_mul_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] op_a = '0, op_b = '0;
  logic        st [2];
  logic        busy [2], done [2], z [2], n [2];
  logic [63:0] prod [2], aa [2], ab [2], res [2];
  logic [5:0]  sh [2];
  logic [3:0]  opt [2];
  int total = 0, bad = 0;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  alu_mul_seq #(.EARLY_EXIT(1'b1)) u_mul1 (.clk(clk), .rst_n(rst_n), .start(st[1]), .op_a(op_a), .op_b(op_b),
    .busy(busy[1]), .done(done[1]), .product(prod[1]), .alu_a(aa[1]), .alu_b(ab[1]),
    .alu_shamt(sh[1]), .alu_opt(opt[1]), .alu_res(res[1]));
  alu u_alu1 (.opt(opt[1]), .a(aa[1]), .b(ab[1]), .shamt(sh[1]), .res(res[1]), .z(z[1]), .n(n[1]));
  alu_mul_seq #(.EARLY_EXIT(1'b0)) u_mul0 (.clk(clk), .rst_n(rst_n), .start(st[0]), .op_a(op_a), .op_b(op_b),
    .busy(busy[0]), .done(done[0]), .product(prod[0]), .alu_a(aa[0]), .alu_b(ab[0]),
    .alu_shamt(sh[0]), .alu_opt(opt[0]), .alu_res(res[0]));
  alu u_alu0 (.opt(opt[0]), .a(aa[0]), .b(ab[0]), .shamt(sh[0]), .res(res[0]), .z(z[0]), .n(n[0]));

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, o, e);
    end
  endtask

  function automatic int explat(input int ee, input logic [63:0] b);
    int msb = -1;
    for (int i = 0; i < 64; i++) if (b[i]) msb = i;
    if (ee == 1 && b == '0) return 1;
    return 1 + $countones(b) + ((ee == 1) ? msb + 1 : 64);
  endfunction

  // lat counts cycles after the accepting edge until done is seen
  task automatic run(input int s, input logic [63:0] a, input logic [63:0] b, input bit hold,
                     output int lat, output int busy_bad, output int alt_bad, output int addb_bad);
    @(negedge clk);
    op_a = a;
    op_b = b;
    st[s] = 1'b1;
    lat = 0; busy_bad = 0; alt_bad = 0; addb_bad = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!hold) st[s] = 1'b0;
      if (!done[s]) begin
        if (busy[s] !== 1'b1) busy_bad++;
        if (opt[s] !== ((lat % 2 == 1) ? 4'd0 : 4'd6)) alt_bad++;
        if (opt[s] == 4'd0 && ab[s] != '0) addb_bad++;
      end
    end while (!done[s] && lat < 400);
  endtask

  initial begin
    int lat, bb, alt, addb, cnt_done;
    logic [63:0] a, b;
    st[0] = 1'b0;
    st[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy[1]), 64'd0);
    check("rst_done", 64'(done[1]), 64'd0);
    check("rst_product", prod[1], 64'd0);
    check("rst_alu_opt", 64'(opt[1]), 64'd0);
    check("rst_alu_a", aa[1], 64'd0);
    rst_n = 1'b1;

    run(1, 64'd7, 64'd6, 1'b0, lat, bb, alt, addb);
    check("t1_lat", 64'(lat), 64'd6);
    check("t1_product", prod[1], 64'd42);
    check("t1_busy_during", 64'(bb), 64'd0);
    check("t1_busy_at_done", 64'(busy[1]), 64'd0);

    run(1, 64'd12345, 64'd0, 1'b0, lat, bb, alt, addb);
    check("t2_ee1_lat", 64'(lat), 64'd1);
    check("t2_ee1_product", prod[1], 64'd0);
    run(0, 64'd12345, 64'd0, 1'b0, lat, bb, alt, addb);
    check("t2_ee0_lat", 64'(lat), 64'd65);
    check("t2_ee0_product", prod[0], 64'd0);
    check("t2_ee0_no_add_nonzero_b", 64'(addb), 64'd0);

    run(1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b0, lat, bb, alt, addb);
    check("t3_neg_lat", 64'(lat), 64'd6);
    check("t3_neg_product", prod[1], 64'hFFFF_FFFF_FFFF_FFF1);
    run(1, 64'h8000_0000_0000_0000, 64'd2, 1'b0, lat, bb, alt, addb);
    check("t3_wrap_lat", 64'(lat), 64'd4);
    check("t3_wrap_product", prod[1], 64'd0);

    run(1, 64'd1, ONES, 1'b0, lat, bb, alt, addb);
    check("t4_ee1_lat", 64'(lat), 64'd129);
    check("t4_ee1_product", prod[1], ONES);
    check("t4_ee1_alternate", 64'(alt), 64'd0);
    run(0, 64'd1, ONES, 1'b0, lat, bb, alt, addb);
    check("t4_ee0_lat", 64'(lat), 64'd129);
    check("t4_ee0_product", prod[0], ONES);
    check("t4_ee0_alternate", 64'(alt), 64'd0);

    run(1, 64'd3, 64'd3, 1'b1, lat, bb, alt, addb);
    check("t5_hold_lat", 64'(lat), 64'd5);
    check("t5_hold_product", prod[1], 64'd9);
    @(negedge clk);
    check("t5_idle_busy", 64'(busy[1]), 64'd0);
    check("t5_idle_done", 64'(done[1]), 64'd0);
    @(negedge clk);
    st[1] = 1'b0;
    check("t5_restart_busy", 64'(busy[1]), 64'd1);
    cnt_done = 0;
    while (!done[1] && cnt_done < 20) begin
      @(negedge clk);
      cnt_done++;
    end
    check("t5_second_done", 64'(done[1]), 64'd1);
    check("t5_second_product", prod[1], 64'd9);

    @(negedge clk);
    op_a = 64'd5;
    op_b = ONES;
    st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    @(negedge clk);
    check("t5_in_shl", 64'(opt[1]), 64'd6);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_busy", 64'(busy[1]), 64'd0);
    check("t5_rst_done", 64'(done[1]), 64'd0);
    check("t5_rst_product", prod[1], 64'd0);
    check("t5_rst_alu_a", aa[1], 64'd0);
    rst_n = 1'b1;
    cnt_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (done[1]) cnt_done++;
    end
    check("t5_rst_no_done", 64'(cnt_done), 64'd0);

    for (int i = 0; i < 150; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      for (int s = 1; s >= 0; s--) begin
        run(s, a, b, 1'b0, lat, bb, alt, addb);
        check($sformatf("rand%0d_ee%0d_lat", i, s), 64'(lat), 64'(explat(s, b)));
        check($sformatf("rand%0d_ee%0d_product", i, s), prod[s], a * b);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
